im_fetch_ctrl: RTL and testbench

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

---
 rtl/cpu_pkg.sv | 18 +
 rtl/im_fetch_ctrl.sv | 101 ++++++++++
 tb/tb_im_fetch_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, default PC increment and
// small address helpers used across the pipeline front end.
package cpu_pkg;

    // Fetch controller states (legacy-compatible encoding)
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Default byte increment between sequential fetches
    localparam int unsigned PC_STEP_DEFAULT = 4;

    // Force a byte address onto a 32-bit word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory address and
// enable, tracks the one-cycle IM response, presents fetched words to decode,
// parks a word in local hold registers while decode stalls, and handles
// redirects with top priority.
module im_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IMaddr,
    output logic        IMen,
    input  logic [31:0] Instruction,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    logic        rsp_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    assign IMaddr = fetch_pc;

    // Output muxing: live IM response in RUN, parked word in HOLD, nothing in BOOT
    always_comb begin
        IMen     = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        if (!redirect_valid) begin
            case (state)
                ST_RUN: begin
                    if_valid = rsp_valid;
                    if_pc    = rsp_pc;
                    if_instr = Instruction;
                    IMen     = !(stall && rsp_valid);
                end
                ST_HOLD: begin
                    if_valid = 1'b1;
                    if_pc    = hold_pc;
                    if_instr = hold_instr;
                    IMen     = !stall;
                end
                default: begin
                    IMen     = 1'b0;
                    if_valid = 1'b0;
                end
            endcase
        end
    end

    // State, fetch PC, response tracking and hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            fetch_pc   <= RESET_PC;
            rsp_pc     <= '0;
            rsp_valid  <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (redirect_valid) begin
            state      <= ST_RUN;
            fetch_pc   <= align_word(redirect_pc);
            rsp_valid  <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            if (IMen) begin
                fetch_pc  <= fetch_pc + 32'(PC_STEP);
                rsp_pc    <= fetch_pc;
                rsp_valid <= 1'b1;
            end else begin
                rsp_valid <= 1'b0;
            end
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (stall && rsp_valid) begin
                        hold_pc    <= rsp_pc;
                        hold_instr <= Instruction;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) state <= ST_RUN;
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: a behavioural one-cycle instruction
// memory, per-scenario tasks with inline checks, and a scoreboard queue of
// expected consumed (pc, instruction) pairs.
module tb_im_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] IMaddr;
    logic        IMen;
    logic [31:0] Instruction;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int vectors;
    int miscompares;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    im_fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .IMaddr        (IMaddr),
        .IMen          (IMen),
        .Instruction   (Instruction),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h0000_0078) return 32'he58da000;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    // Instruction memory: data one cycle after the request, zero when not enabled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) Instruction <= '0;
        else        Instruction <= IMen ? im_word(IMaddr) : 32'h0;
    end

    task automatic tick(input logic s, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(negedge clk);
    endtask

    task automatic hold_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(input logic rv, input logic [31:0] rp);
        redirect_valid = rv;
        redirect_pc    = rp;
        rst_n          = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++;
        if (IMen !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || IMaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: IMen=%b if_valid=%b if_pc=%h if_instr=%h IMaddr=%h, required 0/0/0/0/0",
                     IMen, if_valid, if_pc, if_instr, IMaddr);
        end
    endtask

    task automatic test_sequential();
        hold_reset();
        for (int unsigned p = 0; p < 24; p += 4) exp_q.push_back(p);
        release_reset(1'b0, '0);
        vectors++;
        if (IMen !== 1'b0 || IMaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL boot_cycle: IMen=%b IMaddr=%h, required 0/00000000", IMen, IMaddr);
        end
        for (int c = 1; c <= 7; c++) begin
            tick(1'b0, 1'b0, '0);
            vectors++;
            if (IMen !== 1'b1 || IMaddr !== 32'(4 * (c - 1))) begin
                miscompares++;
                $display("FAIL seq_fetch c%0d: IMen=%b IMaddr=%h, required 1/%h", c, IMen, IMaddr, 32'(4 * (c - 1)));
            end
            if (c == 1) begin
                vectors++;
                if (if_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL seq_first_valid: if_valid=%b at cycle 1, required 0", if_valid);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL seq_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL seq_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL seq_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic s;
        hold_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 9; c++) begin
            s = (c >= 4 && c <= 6);
            tick(s, 1'b0, '0);
            if (s) begin
                vectors++;
                if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== im_word(32'h8) || IMen !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold c%0d: if_valid=%b if_pc=%h if_instr=%h IMen=%b, required 1/8/%h/0",
                             c, if_valid, if_pc, if_instr, IMen, im_word(32'h8));
                end
            end
            if (c == 7) begin
                vectors++;
                if (if_pc !== 32'h8 || IMen !== 1'b1 || IMaddr !== 32'hC) begin
                    miscompares++;
                    $display("FAIL stall_release: if_pc=%h IMen=%b IMaddr=%h, required 8/1/c", if_pc, IMen, IMaddr);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL stall_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        hold_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h78); exp_q.push_back(32'h7C);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 7; c++) begin
            tick(1'b0, c == 4, 32'h78);
            if (c == 4 || c == 5) begin
                vectors++;
                if (if_valid !== 1'b0 || IMen !== (c == 5)) begin
                    miscompares++;
                    $display("FAIL redirect_bubble c%0d: if_valid=%b IMen=%b, required 0/%b", c, if_valid, IMen, c == 5);
                end
            end
            if (c == 5) begin
                vectors++;
                if (IMaddr !== 32'h78) begin
                    miscompares++;
                    $display("FAIL redirect_addr: IMaddr=%h, required 00000078", IMaddr);
                end
            end
            if (c == 6) begin
                vectors++;
                if (if_valid !== 1'b1 || if_pc !== 32'h78 || if_instr !== 32'he58da000) begin
                    miscompares++;
                    $display("FAIL redirect_target: if_valid=%b if_pc=%h if_instr=%h, required 1/78/e58da000", if_valid, if_pc, if_instr);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL redirect_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL redirect_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL redirect_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        hold_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 7; c++) begin
            tick(1'b0, c == 3 || c == 4, (c == 3) ? 32'h40 : 32'h100);
            if (c == 4) begin
                vectors++;
                if (IMen !== 1'b0 || IMaddr !== 32'h40) begin
                    miscompares++;
                    $display("FAIL b2b_middle: IMen=%b IMaddr=%h, required 0/40", IMen, IMaddr);
                end
            end
            if (c == 5) begin
                vectors++;
                if (IMen !== 1'b1 || IMaddr !== 32'h100) begin
                    miscompares++;
                    $display("FAIL b2b_last: IMen=%b IMaddr=%h, required 1/100", IMen, IMaddr);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL b2b_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_hold_redirect();
        logic s;
        hold_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h78); exp_q.push_back(32'h7C);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 8; c++) begin
            s = (c == 4 || c == 5);
            tick(s, c == 5, 32'h7B);
            if (c == 5) begin
                vectors++;
                if (if_valid !== 1'b0 || IMen !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_redir_cycle: if_valid=%b IMen=%b, required 0/0", if_valid, IMen);
                end
            end
            if (c == 6) begin
                vectors++;
                if (if_valid !== 1'b0 || IMen !== 1'b1 || IMaddr !== 32'h78) begin
                    miscompares++;
                    $display("FAIL hold_redir_align: if_valid=%b IMen=%b IMaddr=%h, required 0/1/78", if_valid, IMen, IMaddr);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL hold_redir_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL hold_redir_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_redir_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_boot_redirect();
        hold_reset();
        exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
        release_reset(1'b1, 32'h10);
        vectors++;
        if (IMen !== 1'b0 || if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_redir_cycle: IMen=%b if_valid=%b, required 0/0", IMen, if_valid);
        end
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 1'b0, '0);
            if (c == 1) begin
                vectors++;
                if (IMen !== 1'b1 || IMaddr !== 32'h10) begin
                    miscompares++;
                    $display("FAIL boot_redir_addr: IMen=%b IMaddr=%h, required 1/10", IMen, IMaddr);
                end
            end
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL boot_redir_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL boot_redir_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL boot_redir_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 6; c++) begin
            tick(1'b0, c == 2, 32'hFFFF_FFFE);
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wrap_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL wrap_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_in_hold();
        hold_reset();
        release_reset(1'b0, '0);
        for (int c = 1; c <= 5; c++) tick(c >= 4, 1'b0, '0);
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL rst_hold_setup: if_valid=%b if_pc=%h, required 1/8", if_valid, if_pc);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || IMen !== 1'b0 || IMaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_hold_async: if_valid=%b if_pc=%h if_instr=%h IMen=%b IMaddr=%h, required 0/0/0/0/0",
                     if_valid, if_pc, if_instr, IMen, IMaddr);
        end
        stall = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        @(negedge clk);
        release_reset(1'b0, '0);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, 1'b0, '0);
            if (if_valid && !stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rst_hold_stream: unexpected if_pc=%h", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (if_pc !== exp_pc || if_instr !== im_word(exp_pc)) begin
                        miscompares++;
                        $display("FAIL rst_hold_stream: if_pc=%h if_instr=%h, required %h/%h", if_pc, if_instr, exp_pc, im_word(exp_pc));
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_hold_drain: %0d expected words not presented, required 0", exp_q.size());
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_hold_redirect();
        test_boot_redirect();
        test_wrap();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
